// File: rtl/ariane_pkg.sv
// Shared types and defaults for the BOF range-table controller.
package ariane_pkg;

    localparam int unsigned BOF_NUM_ENTRIES = 8;
    localparam int unsigned BOF_ADDR_W      = 32;
    // Entries store addresses zero-extended to this width so any ADDR_W up to it compares unsigned.
    localparam int unsigned BOF_MAX_ADDR_W  = 64;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } bof_state_e;

    typedef struct packed {
        logic                      valid;
        logic [BOF_MAX_ADDR_W-1:0] start_addr;
        logic [BOF_MAX_ADDR_W-1:0] end_addr;
    } bof_range_t;

endpackage

// File: rtl/bof_range_match.sv
// Parallel inclusive range compare over every entry, lowest matching index wins.
module bof_range_match
    import ariane_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = BOF_NUM_ENTRIES
) (
    input  bof_range_t                       entries_i [NUM_ENTRIES],
    input  logic [BOF_MAX_ADDR_W-1:0]        addr_i,
    output logic                             hit_c,
    output logic [$clog2(NUM_ENTRIES)-1:0]   idx_c
);

    localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);

    logic [NUM_ENTRIES-1:0] match;

    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            match[i] = entries_i[i].valid
                    && (entries_i[i].start_addr <= addr_i)
                    && (addr_i <= entries_i[i].end_addr);
        end
    end

    // Scan downward so the lowest matching index is the last one written.
    always_comb begin
        hit_c = 1'b0;
        idx_c = '0;
        for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_c = 1'b1;
                idx_c = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bof_range_ctrl.sv
// Range table with two arbitrated insert ports, one-entry-per-cycle flush and registered lookup.
module bof_range_ctrl
    import ariane_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = BOF_NUM_ENTRIES,
    parameter int unsigned ADDR_W      = BOF_ADDR_W
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             req0_valid_i,
    output logic                             req0_ready_o,
    input  logic [ADDR_W-1:0]                req0_start_i,
    input  logic [ADDR_W-1:0]                req0_end_i,
    input  logic                             req1_valid_i,
    output logic                             req1_ready_o,
    input  logic [ADDR_W-1:0]                req1_start_i,
    input  logic [ADDR_W-1:0]                req1_end_i,
    input  logic                             clear_i,
    input  logic                             lookup_valid_i,
    input  logic [ADDR_W-1:0]                lookup_addr_i,
    output logic                             lookup_hit_o,
    output logic [$clog2(NUM_ENTRIES)-1:0]   lookup_idx_o,
    output logic                             busy_o,
    output logic [$clog2(NUM_ENTRIES):0]     count_o,
    output logic                             overwrite_o,
    output logic                             err_o
);

    localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
    localparam int unsigned CNT_W = IDX_W + 1;

    bof_state_e                state_q, state_d;
    bof_range_t                tbl_q [NUM_ENTRIES];
    logic [IDX_W-1:0]          wr_ptr_q, clr_ptr_q;
    logic                      rr_q;
    logic [CNT_W-1:0]          count_q;
    logic                      hit_q, ovw_q, err_q, busy_q;
    logic [IDX_W-1:0]          idx_q;

    logic                      open, acc0, ins_fire, ins_src, ins_ok, clr_last;
    logic [BOF_MAX_ADDR_W-1:0] ins_start, ins_end, qry_addr;
    logic                      m_hit;
    logic [IDX_W-1:0]          m_idx;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (clear_i)  state_d = ST_CLEAR;
            ST_CLEAR: if (clr_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Handshake, arbitration and insert decode
    always_comb begin
        open         = (state_q == ST_IDLE) && !clear_i;
        req0_ready_o = open && (!req1_valid_i || !rr_q);
        req1_ready_o = open && (!req0_valid_i ||  rr_q);
        acc0         = req0_valid_i && req0_ready_o;
        ins_fire     = acc0 || (req1_valid_i && req1_ready_o);
        ins_src      = !acc0;
        ins_start    = ins_src ? BOF_MAX_ADDR_W'(req1_start_i) : BOF_MAX_ADDR_W'(req0_start_i);
        ins_end      = ins_src ? BOF_MAX_ADDR_W'(req1_end_i)   : BOF_MAX_ADDR_W'(req0_end_i);
        ins_ok       = ins_fire && (ins_start <= ins_end);
        clr_last     = (clr_ptr_q == IDX_W'(NUM_ENTRIES - 1));
        qry_addr     = BOF_MAX_ADDR_W'(lookup_addr_i);
    end

    bof_range_match #(
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_match (
        .entries_i (tbl_q),
        .addr_i    (qry_addr),
        .hit_c     (m_hit),
        .idx_c     (m_idx)
    );

    // Table, pointers and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) tbl_q[i] <= '0;
            wr_ptr_q  <= '0;
            clr_ptr_q <= '0;
            rr_q      <= 1'b0;
            count_q   <= '0;
            hit_q     <= 1'b0;
            idx_q     <= '0;
            ovw_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            ovw_q  <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= (state_d == ST_CLEAR);
            hit_q  <= lookup_valid_i && (state_q == ST_IDLE) && m_hit;
            idx_q  <= (lookup_valid_i && (state_q == ST_IDLE) && m_hit) ? m_idx : '0;

            if (ins_fire) begin
                rr_q <= ~ins_src;
                if (!ins_ok) err_q <= 1'b1;
            end
            if (ins_ok) begin
                tbl_q[wr_ptr_q] <= '{valid: 1'b1, start_addr: ins_start, end_addr: ins_end};
                wr_ptr_q        <= wr_ptr_q + IDX_W'(1);
                if (tbl_q[wr_ptr_q].valid) ovw_q   <= 1'b1;
                else                       count_q <= count_q + CNT_W'(1);
            end

            if ((state_q == ST_IDLE) && clear_i) clr_ptr_q <= '0;
            if (state_q == ST_CLEAR) begin
                tbl_q[clr_ptr_q].valid <= 1'b0;
                clr_ptr_q              <= clr_ptr_q + IDX_W'(1);
                if (tbl_q[clr_ptr_q].valid) count_q <= count_q - CNT_W'(1);
                if (clr_last) begin
                    wr_ptr_q <= '0;
                    count_q  <= '0;
                end
            end
        end
    end

    assign lookup_hit_o = hit_q;
    assign lookup_idx_o = idx_q;
    assign busy_o       = busy_q;
    assign count_o      = count_q;
    assign overwrite_o  = ovw_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_bof_range_ctrl.sv
// Randomized bench for bof_range_ctrl against a behavioural table model.
module tb_bof_range_ctrl;

    localparam int N = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req0_valid_i, req1_valid_i, clear_i, lookup_valid_i;
    logic [31:0] req0_start_i, req0_end_i, req1_start_i, req1_end_i, lookup_addr_i;
    logic        req0_ready_o, req1_ready_o, lookup_hit_o, busy_o, overwrite_o, err_o;
    logic [2:0]  lookup_idx_o;
    logic [3:0]  count_o;

    int n_chk = 0;
    int n_bad = 0;

    // Model state: the table as plain arrays plus pointers and remaining flush cycles.
    bit          m_valid [N];
    logic [31:0] m_start [N];
    logic [31:0] m_end   [N];
    int          m_wr, m_rr, m_clr_left;

    bof_range_ctrl #(.NUM_ENTRIES(N), .ADDR_W(32)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req0_valid_i   (req0_valid_i),
        .req0_ready_o   (req0_ready_o),
        .req0_start_i   (req0_start_i),
        .req0_end_i     (req0_end_i),
        .req1_valid_i   (req1_valid_i),
        .req1_ready_o   (req1_ready_o),
        .req1_start_i   (req1_start_i),
        .req1_end_i     (req1_end_i),
        .clear_i        (clear_i),
        .lookup_valid_i (lookup_valid_i),
        .lookup_addr_i  (lookup_addr_i),
        .lookup_hit_o   (lookup_hit_o),
        .lookup_idx_o   (lookup_idx_o),
        .busy_o         (busy_o),
        .count_o        (count_o),
        .overwrite_o    (overwrite_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_valid[i]);
        return c;
    endfunction

    task automatic idle_inputs();
        req0_valid_i = 0; req1_valid_i = 0; clear_i = 0; lookup_valid_i = 0;
        req0_start_i = 0; req0_end_i = 0; req1_start_i = 0; req1_end_i = 0;
        lookup_addr_i = 0;
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        idle_inputs();
        #2;
        check_eq("rst_hit",   lookup_hit_o, 0);
        check_eq("rst_idx",   lookup_idx_o, 0);
        check_eq("rst_count", count_o, 0);
        check_eq("rst_busy",  busy_o, 0);
        check_eq("rst_ovw",   overwrite_o, 0);
        check_eq("rst_err",   err_o, 0);
        for (int i = 0; i < N; i++) m_valid[i] = 0;
        m_wr = 0; m_rr = 0; m_clr_left = 0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    // One clock: inputs already driven; check handshake, advance model, check registered outputs.
    task automatic step();
        bit          open, e_hit, e_ovw, e_err;
        int          win, e_idx;
        logic [31:0] s, e;
        open = (m_clr_left == 0) && !clear_i;
        win  = -1;
        if (open) begin
            if (req0_valid_i && req1_valid_i) win = m_rr;
            else if (req0_valid_i)            win = 0;
            else if (req1_valid_i)            win = 1;
        end
        #1;
        if (!open) begin
            check_eq("rdy0_closed", req0_ready_o, 0);
            check_eq("rdy1_closed", req1_ready_o, 0);
        end
        check_eq("acc0", req0_valid_i & req0_ready_o, (win == 0));
        check_eq("acc1", req1_valid_i & req1_ready_o, (win == 1));

        e_hit = 0; e_idx = 0;
        if (lookup_valid_i && m_clr_left == 0)
            for (int i = 0; i < N; i++)
                if (!e_hit && m_valid[i] && m_start[i] <= lookup_addr_i && lookup_addr_i <= m_end[i]) begin
                    e_hit = 1; e_idx = i;
                end

        e_ovw = 0; e_err = 0;
        if (m_clr_left > 0) begin
            m_valid[N - m_clr_left] = 0;
            m_clr_left--;
            if (m_clr_left == 0) m_wr = 0;
        end else if (clear_i) begin
            m_clr_left = N;
        end else if (win >= 0) begin
            s = (win == 1) ? req1_start_i : req0_start_i;
            e = (win == 1) ? req1_end_i   : req0_end_i;
            m_rr = 1 - win;
            if (s <= e) begin
                e_ovw = m_valid[m_wr];
                m_valid[m_wr] = 1; m_start[m_wr] = s; m_end[m_wr] = e;
                m_wr = (m_wr + 1) % N;
            end else begin
                e_err = 1;
            end
        end

        @(posedge clk_i); #1;
        check_eq("hit",   lookup_hit_o, e_hit);
        check_eq("idx",   lookup_idx_o, e_idx);
        check_eq("ovw",   overwrite_o, e_ovw);
        check_eq("err",   err_o, e_err);
        check_eq("busy",  busy_o, (m_clr_left > 0));
        check_eq("count", count_o, model_count());
    endtask

    task automatic cyc(input bit v0, input logic [31:0] s0, input logic [31:0] e0,
                       input bit v1, input logic [31:0] s1, input logic [31:0] e1,
                       input bit clr, input bit lv, input logic [31:0] la);
        req0_valid_i = v0; req0_start_i = s0; req0_end_i = e0;
        req1_valid_i = v1; req1_start_i = s1; req1_end_i = e1;
        clear_i = clr; lookup_valid_i = lv; lookup_addr_i = la;
        step();
    endtask

    initial begin
        logic [31:0] s0, s1;
        idle_inputs();
        #1;
        apply_reset();

        // Single insert then inclusive-end hit and one-past-end miss.
        cyc(1, 32'h1000, 32'h10FF, 0, 0, 0, 0, 0, 0);
        check_eq("first_count", count_o, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h10FF);
        check_eq("end_hit", lookup_hit_o, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h1100);
        check_eq("past_miss", lookup_hit_o, 0);

        // Both requesters contending: alternate grants.
        for (int k = 0; k < 4; k++)
            cyc(1, 32'h3000 + 32'(k * 16'h100), 32'h30FF + 32'(k * 16'h100),
                1, 32'h5000 + 32'(k * 16'h100), 32'h50FF + 32'(k * 16'h100), 0, 1, 32'h1080);

        // Fill past capacity to force an overwrite of entry 0.
        for (int k = 0; k < 4; k++)
            cyc(0, 0, 0, 1, 32'h7000 + 32'(k * 16'h10), 32'h700F + 32'(k * 16'h10), 0, 1, 32'h3000);
        check_eq("full_count", count_o, N);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h1000);
        check_eq("overwritten_miss", lookup_hit_o, 0);

        // Inverted range dropped.
        cyc(1, 32'h2000, 32'h1FFF, 0, 0, 0, 0, 0, 0);
        check_eq("inv_err", err_o, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h2000);

        // Flush with a competing insert, lookups during flush, then insert lands at entry 0.
        cyc(0, 0, 0, 1, 32'h9000, 32'h90FF, 1, 1, 32'h7000);
        for (int k = 0; k < N; k++) cyc(0, 0, 0, 1, 32'h9000, 32'h90FF, 1, 1, 32'h7000);
        check_eq("post_clear_busy", busy_o, 0);
        cyc(1, 32'hA000, 32'hA0FF, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'hA000);
        check_eq("land_idx0", lookup_idx_o, 0);

        // Reset three cycles into a flush.
        cyc(1, 32'h100, 32'h1FF, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'hA000);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h150);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 499) == 0) apply_reset();
            s0 = 32'($urandom_range(0, 200));
            s1 = 32'($urandom_range(0, 200));
            cyc($urandom_range(0, 1) == 1, s0,
                ($urandom_range(0, 9) == 0) ? s0 - 1 : s0 + 32'($urandom_range(0, 60)),
                $urandom_range(0, 1) == 1, s1,
                ($urandom_range(0, 9) == 0) ? s1 - 1 : s1 + 32'($urandom_range(0, 60)),
                $urandom_range(0, 39) == 0,
                $urandom_range(0, 3) != 0, 32'($urandom_range(0, 270)));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/bof_range_ctrl.md
BOF_RANGE_CTRL -- requirements
Module: bof_range_ctrl

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 8, range-table depth (power of two, >=2).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have port clk_i  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports reqN_valid_i in 1, reqN_ready_o out 1, reqN_start_i in ADDR_W, reqN_end_i in ADDR_W (N=0,1): two range-insert requesters, valid/ready.
REQ-006 SHALL have port clear_i  in  1  flush-table request (level, sampled in IDLE).
REQ-007 SHALL have ports lookup_valid_i in 1, lookup_addr_i in ADDR_W: range query.
REQ-008 SHALL have ports lookup_hit_o out 1, lookup_idx_o out log2(NUM_ENTRIES): registered query result.
REQ-009 SHALL have ports busy_o out 1 (clear in progress), count_o out log2(NUM_ENTRIES)+1 (valid entries), overwrite_o out 1 (pulse), err_o out 1 (pulse).

Function
REQ-010 SHALL hold NUM_ENTRIES entries {valid, start, end}, write pointer wr_ptr, round-robin pointer rr, FSM states IDLE and CLEAR.
REQ-011 reqN_ready_o SHALL be 1 only when state==IDLE and clear_i==0; at most one insert accepted per cycle.
REQ-012 Both valid in same cycle: grant to requester rr; rr SHALL toggle to the other requester after every grant; single valid requester granted regardless of rr.
REQ-013 Accepted insert with start<=end (unsigned) SHALL write entry[wr_ptr], set valid, wr_ptr=(wr_ptr+1) mod NUM_ENTRIES (wrap to 0).
REQ-014 Insert into an already-valid slot SHALL overwrite it (oldest-first), count_o unchanged (saturates at NUM_ENTRIES), overwrite_o=1 next cycle for one cycle.
REQ-015 Accepted insert with start>end SHALL be dropped (no table/pointer change), err_o=1 next cycle for one cycle; rr still toggles.
REQ-016 IDLE with clear_i=1: -> CLEAR, clear pointer=0; clear wins over simultaneous inserts (not accepted).
REQ-017 CLEAR SHALL invalidate one entry per cycle, index 0..NUM_ENTRIES-1, then -> IDLE with wr_ptr=0, count_o=0; exactly NUM_ENTRIES cycles in CLEAR; busy_o=1 throughout.
REQ-018 clear_i while in CLEAR SHALL be ignored (no restart).
REQ-019 Lookup: hit when some valid entry has start<=addr<=end (unsigned, inclusive both ends); lowest matching index reported; result on lookup_hit_o/lookup_idx_o one cycle after lookup_valid_i.
REQ-020 lookup_hit_o SHALL be 0 (idx 0) when lookup_valid_i was 0, no match, or state was CLEAR in the query cycle.
REQ-021 Lookup same cycle as insert SHALL see table before the insert; insert visible to lookups one cycle later.
REQ-022 count_o SHALL reflect table state after the last edge (registered).

Reset
REQ-023 On rst_i (asynchronous): all entries invalid, wr_ptr=0, rr=0, state IDLE, count_o=0, lookup_hit_o=0, lookup_idx_o=0, overwrite_o=0, err_o=0, busy_o=0.
REQ-024 Reset asserted mid-CLEAR or mid-insert SHALL abort immediately to the reset state; no partial write survives.

Structure
REQ-025 Range entry struct (valid, start, end) and FSM state enum SHALL live in ariane_pkg; NUM_ENTRIES default as a package constant.
REQ-026 One sub-module SHALL be used: bof_range_match (combinational parallel compare + lowest-index priority encode over all entries).
REQ-027 Total RTL SHALL be 120-400 lines.

Verification
REQ-028 Reset, req0 {0x1000,0x10FF} -> ready=1, count_o=1; lookup 0x10FF -> next cycle hit=1, idx=0; lookup 0x1100 -> hit=0.
REQ-029 req0 and req1 valid 4 consecutive cycles -> grants 0,1,0,1; entries 0..3 alternate sources; count_o=4.
REQ-030 9 inserts, NUM_ENTRIES=8 -> 9th writes entry 0, overwrite_o one-cycle pulse, count_o=8, wr_ptr=1.
REQ-031 Insert {0x2000,0x1FFF} -> err_o pulse, count_o unchanged, lookup 0x2000 hit=0.
REQ-032 3 entries, clear_i=1 with req1_valid_i=1 -> req1_ready_o=0, busy_o=1 exactly 8 cycles, lookups during clear hit=0, afterwards count_o=0 and next insert lands in entry 0.
REQ-033 rst_i asserted 3 cycles into CLEAR -> immediately IDLE, busy_o=0, all lookups miss.
